// File: rtl/rvcpu_mem_arbiter_if.sv
// Unified memory bus between the rvcpu arbiter and the memory model.
// One outstanding transaction; bus_ack pulses on completion.
interface rvcpu_mem_arbiter_if;
  logic        bus_req;
  logic        bus_wen;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_wen,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_wen,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/rvcpu_mem_arbiter.sv
// Fetch/data arbiter onto one memory bus: data priority, bounded
// fetch starvation, one outstanding transaction with timeout.
module rvcpu_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_err,
  rvcpu_mem_arbiter_if.master bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    RESP_IF,
    RESP_MEM
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo;
  logic          sel_hi;

  logic both;
  logic grant_mem;
  logic expire;
  logic done;
  logic unused_bits;

  assign unused_bits = ^{if_addr[1:0], mem_addr[2:0]};

  always_comb begin
    both      = if_req && mem_req;
    grant_mem = mem_req
             && (!if_req || (streak < SW'(STARVE_MAX)));
    expire    = (tmo == TW'(TIMEOUT - 1));
    done      = bus.bus_ack || expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      streak        <= '0;
      tmo           <= '0;
      sel_hi        <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_wen   <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      if_rdata      <= '0;
      if_valid      <= 1'b0;
      if_err        <= 1'b0;
      mem_rdata     <= '0;
      mem_rvalid    <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      if_valid   <= 1'b0;
      if_err     <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo <= '0;
          if (grant_mem) begin
            state         <= BUSY_MEM;
            bus.bus_req   <= 1'b1;
            bus.bus_wen   <= mem_wen;
            bus.bus_addr  <= {32'b0, mem_addr[31:3], 3'b0};
            bus.bus_wdata <= mem_wdata;
            streak        <= both ? streak + 1'b1 : '0;
          end else if (if_req) begin
            state         <= BUSY_IF;
            bus.bus_req   <= 1'b1;
            bus.bus_wen   <= 1'b0;
            bus.bus_addr  <= {if_addr[63:3], 3'b0};
            bus.bus_wdata <= '0;
            sel_hi        <= if_addr[2];
            streak        <= '0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (done) begin
            bus.bus_req <= 1'b0;
            tmo         <= '0;
            if (state == BUSY_IF) begin
              state    <= RESP_IF;
              if_valid <= 1'b1;
              if_err   <= !bus.bus_ack;
              if (!bus.bus_ack)
                if_rdata <= '0;
              else if (sel_hi)
                if_rdata <= bus.bus_rdata[63:32];
              else
                if_rdata <= bus.bus_rdata[31:0];
            end else begin
              state      <= RESP_MEM;
              mem_rvalid <= 1'b1;
              mem_err    <= !bus.bus_ack;
              // writes and timeouts both return zero data
              mem_rdata  <= (bus.bus_ack && !bus.bus_wen)
                          ? bus.bus_rdata : '0;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
